// File: rtl/rvh2rrv_ruby_ld_resp_trans.sv
// ---------------------------------------------------------------------------
// rvh2rrv_ruby_ld_resp_trans
//
// Return-path translator between the rvh L1D and the rrv64 ruby tester.
// Ruby load requests park their line offset and size/sign opcode in a
// tag-indexed table. When the L1D returns the full line for a tag, the
// addressed bytes are extracted and sign/zero-extended to register width.
// The result is then queued in a small FIFO and handed to the ruby tester
// over valid/ready.
//
// Optional feature: define RUBY_LD_MISALIGN_CHK_EN to flag loads whose
// offset is not a multiple of the access size. Such results carry
// misalign=1 and zero data. When the macro is undefined, misalign is tied 0.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   ruby_ld_req_*                  load request (tag, offset, opcode) in
//   l1d_ld_resp_*                  L1D line response (tag, line) in
//   ruby_ld_resp_*                 extended load result out (FIFO head)
//   unexp_resp_err_o               sticky: response for a non-outstanding tag
// ---------------------------------------------------------------------------
module rvh2rrv_ruby_ld_resp_trans #(
  parameter int RRV64_INT_REG_DATA_W = 64,
  parameter int LINE_W               = 512,
  parameter int OFFSET_W             = 6,
  parameter int TAG_W                = 3,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ruby_ld_req_vld_i,
  output logic                            ruby_ld_req_rdy_o,
  input  logic [TAG_W-1:0]                ruby_ld_req_tag_i,
  input  logic [OFFSET_W-1:0]             ruby_ld_req_offset_i,
  input  logic [2:0]                      ruby_ld_req_opcode_i,
  input  logic                            l1d_ld_resp_vld_i,
  output logic                            l1d_ld_resp_rdy_o,
  input  logic [TAG_W-1:0]                l1d_ld_resp_tag_i,
  input  logic [LINE_W-1:0]               l1d_ld_resp_line_i,
  output logic                            ruby_ld_resp_vld_o,
  input  logic                            ruby_ld_resp_rdy_i,
  output logic [TAG_W-1:0]                ruby_ld_resp_tag_o,
  output logic [RRV64_INT_REG_DATA_W-1:0] ruby_ld_resp_data_o,
  output logic                            ruby_ld_resp_misalign_o,
  output logic                            unexp_resp_err_o
);

  localparam int W       = RRV64_INT_REG_DATA_W;
  localparam int ENTRIES = 1 << TAG_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  // Shift the line down so the addressed byte lands at bit 0. Zeros shift in
  // from the top, so bytes past the end of the line read as 0 (no wrap).
  function automatic logic [W-1:0] extract_data(input logic [LINE_W-1:0] line,
                                                input logic [OFFSET_W-1:0] off,
                                                input logic [2:0] op);
    logic signed [W-1:0] raw;
    logic                sgn;
    raw = W'(line >> {off, 3'b000});
    case (op[1:0])
      2'd0: begin
        sgn = ~op[2] & raw[7];
        extract_data = {{(W-8){sgn}}, raw[7:0]};
      end
      2'd1: begin
        sgn = ~op[2] & raw[15];
        extract_data = {{(W-16){sgn}}, raw[15:0]};
      end
      2'd2: begin
        sgn = ~op[2] & raw[31];
        extract_data = {{(W-32){sgn}}, raw[31:0]};
      end
      default: begin
        extract_data = raw;
      end
    endcase
  endfunction

`ifdef RUBY_LD_MISALIGN_CHK_EN
  function automatic logic is_misaligned(input logic [OFFSET_W-1:0] off,
                                         input logic [1:0] size);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = |off[1:0];
      default: is_misaligned = |off[2:0];
    endcase
  endfunction
`endif

  // Request table
  logic [ENTRIES-1:0]  busy;
  logic [OFFSET_W-1:0] off_tbl [ENTRIES];
  logic [2:0]          op_tbl  [ENTRIES];

  // Result FIFO
  logic [TAG_W-1:0]    fifo_tag  [FIFO_DEPTH];
  logic [W-1:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                err;

`ifdef RUBY_LD_MISALIGN_CHK_EN
  logic                mis_tbl  [ENTRIES];
  logic                fifo_mis [FIFO_DEPTH];
`endif

  logic         req_acc;
  logic         resp_acc;
  logic         push;
  logic         pop;
  logic         fifo_vld;
  logic [W-1:0] push_data;

  // A same-cycle response on the requested tag does not make the tag ready
  // until the next cycle, because readiness uses the registered busy bit.
  assign ruby_ld_req_rdy_o = ~busy[ruby_ld_req_tag_i];
  assign l1d_ld_resp_rdy_o = (count < CNT_W'(FIFO_DEPTH));
  assign req_acc           = ruby_ld_req_vld_i & ruby_ld_req_rdy_o;
  assign resp_acc          = l1d_ld_resp_vld_i & l1d_ld_resp_rdy_o;
  assign push              = resp_acc & busy[l1d_ld_resp_tag_i];
  assign fifo_vld          = (count != '0);
  assign pop               = fifo_vld & ruby_ld_resp_rdy_i;

  always_comb begin
    push_data = extract_data(l1d_ld_resp_line_i,
                             off_tbl[l1d_ld_resp_tag_i],
                             op_tbl[l1d_ld_resp_tag_i]);
`ifdef RUBY_LD_MISALIGN_CHK_EN
    if (mis_tbl[l1d_ld_resp_tag_i]) push_data = '0;
`endif
  end

  // Control state: busy bits, FIFO pointers/count, sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (req_acc) busy[ruby_ld_req_tag_i] <= 1'b1;
      if (push)    busy[l1d_ld_resp_tag_i] <= 1'b0;
      if (resp_acc && !busy[l1d_ld_resp_tag_i]) err <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Table and FIFO payload storage; validity is tracked by the control state
  always_ff @(posedge clk) begin
    if (req_acc) begin
      off_tbl[ruby_ld_req_tag_i] <= ruby_ld_req_offset_i;
      op_tbl[ruby_ld_req_tag_i]  <= ruby_ld_req_opcode_i;
`ifdef RUBY_LD_MISALIGN_CHK_EN
      mis_tbl[ruby_ld_req_tag_i] <= is_misaligned(ruby_ld_req_offset_i,
                                                  ruby_ld_req_opcode_i[1:0]);
`endif
    end
    if (push) begin
      fifo_tag[wr_ptr]  <= l1d_ld_resp_tag_i;
      fifo_data[wr_ptr] <= push_data;
`ifdef RUBY_LD_MISALIGN_CHK_EN
      fifo_mis[wr_ptr]  <= mis_tbl[l1d_ld_resp_tag_i];
`endif
    end
  end

  // Payload is masked while empty so stale storage never shows after reset
  assign ruby_ld_resp_vld_o  = fifo_vld;
  assign ruby_ld_resp_tag_o  = fifo_vld ? fifo_tag[rd_ptr]  : '0;
  assign ruby_ld_resp_data_o = fifo_vld ? fifo_data[rd_ptr] : '0;
`ifdef RUBY_LD_MISALIGN_CHK_EN
  assign ruby_ld_resp_misalign_o = fifo_vld & fifo_mis[rd_ptr];
`else
  assign ruby_ld_resp_misalign_o = 1'b0;
`endif
  assign unexp_resp_err_o = err;

endmodule

// File: tb/tb_rvh2rrv_ruby_ld_resp_trans.sv
module tb_rvh2rrv_ruby_ld_resp_trans;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ruby_ld_req_vld_i;
  logic         ruby_ld_req_rdy_o;
  logic [2:0]   ruby_ld_req_tag_i;
  logic [5:0]   ruby_ld_req_offset_i;
  logic [2:0]   ruby_ld_req_opcode_i;
  logic         l1d_ld_resp_vld_i;
  logic         l1d_ld_resp_rdy_o;
  logic [2:0]   l1d_ld_resp_tag_i;
  logic [511:0] l1d_ld_resp_line_i;
  logic         ruby_ld_resp_vld_o;
  logic         ruby_ld_resp_rdy_i;
  logic [2:0]   ruby_ld_resp_tag_o;
  logic [63:0]  ruby_ld_resp_data_o;
  logic         ruby_ld_resp_misalign_o;
  logic         unexp_resp_err_o;

  typedef struct packed {
    logic [2:0]  tag;
    logic [63:0] data;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  rvh2rrv_ruby_ld_resp_trans dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .ruby_ld_req_vld_i       (ruby_ld_req_vld_i),
    .ruby_ld_req_rdy_o       (ruby_ld_req_rdy_o),
    .ruby_ld_req_tag_i       (ruby_ld_req_tag_i),
    .ruby_ld_req_offset_i    (ruby_ld_req_offset_i),
    .ruby_ld_req_opcode_i    (ruby_ld_req_opcode_i),
    .l1d_ld_resp_vld_i       (l1d_ld_resp_vld_i),
    .l1d_ld_resp_rdy_o       (l1d_ld_resp_rdy_o),
    .l1d_ld_resp_tag_i       (l1d_ld_resp_tag_i),
    .l1d_ld_resp_line_i      (l1d_ld_resp_line_i),
    .ruby_ld_resp_vld_o      (ruby_ld_resp_vld_o),
    .ruby_ld_resp_rdy_i      (ruby_ld_resp_rdy_i),
    .ruby_ld_resp_tag_o      (ruby_ld_resp_tag_o),
    .ruby_ld_resp_data_o     (ruby_ld_resp_data_o),
    .ruby_ld_resp_misalign_o (ruby_ld_resp_misalign_o),
    .unexp_resp_err_o        (unexp_resp_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (ruby_ld_resp_vld_o === 1'b1 && ruby_ld_resp_rdy_i === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got tag %0d data %h, expected no output",
                   ruby_ld_resp_tag_o, ruby_ld_resp_data_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_tag",  64'(ruby_ld_resp_tag_o),      64'(e.tag));
          chk("resp_data", ruby_ld_resp_data_o,          e.data);
          chk("resp_mis",  64'(ruby_ld_resp_misalign_o), 64'(e.mis));
        end
      end
    end
  end

  task automatic req(input logic [2:0] tag, input logic [5:0] off, input logic [2:0] op);
    ruby_ld_req_vld_i    = 1'b1;
    ruby_ld_req_tag_i    = tag;
    ruby_ld_req_offset_i = off;
    ruby_ld_req_opcode_i = op;
    @(negedge clk);
    chk("req_rdy", 64'(ruby_ld_req_rdy_o), 64'd1);
    @(posedge clk);
    #1 ruby_ld_req_vld_i = 1'b0;
  endtask

  task automatic resp(input logic [2:0] tag, input logic [511:0] line,
                      input bit push, input logic [63:0] d, input logic m);
    int cnt;
    exp_t e;
    l1d_ld_resp_vld_i  = 1'b1;
    l1d_ld_resp_tag_i  = tag;
    l1d_ld_resp_line_i = line;
    cnt = 0;
    @(negedge clk);
    while (l1d_ld_resp_rdy_o !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) begin
      n_checks++;
      n_errors++;
      $display("FAIL resp_accept_timeout: got rdy %b, expected 1", l1d_ld_resp_rdy_o);
    end
    @(posedge clk);
    #1 l1d_ld_resp_vld_i = 1'b0;
    if (push) begin
      e.tag = tag; e.data = d; e.mis = m;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int cnt;
    @(posedge clk);
    #1 ruby_ld_resp_rdy_i = 1'b1;
    cnt = 0;
    while (sb.size() != 0 && cnt < 100) begin
      @(posedge clk);
      cnt++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [511:0] ln;
  exp_t         e5;

  initial begin
    rst_n = 1'b0;
    ruby_ld_req_vld_i = 1'b0; ruby_ld_req_tag_i = '0;
    ruby_ld_req_offset_i = '0; ruby_ld_req_opcode_i = '0;
    l1d_ld_resp_vld_i = 1'b0; l1d_ld_resp_tag_i = '0; l1d_ld_resp_line_i = '0;
    ruby_ld_resp_rdy_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_req_rdy",  64'(ruby_ld_req_rdy_o),       64'd1);
    chk("rst_resp_rdy", 64'(l1d_ld_resp_rdy_o),       64'd1);
    chk("rst_vld",      64'(ruby_ld_resp_vld_o),      64'd0);
    chk("rst_data",     ruby_ld_resp_data_o,          64'd0);
    chk("rst_tag",      64'(ruby_ld_resp_tag_o),      64'd0);
    chk("rst_mis",      64'(ruby_ld_resp_misalign_o), 64'd0);
    chk("rst_err",      64'(unexp_resp_err_o),        64'd0);
    @(posedge clk); #1;

    // LB tag2 offset 0x10, byte16 = 0x80; result one cycle after accept
    req(3'd2, 6'h10, 3'b000);
    chk("idle_vld", 64'(ruby_ld_resp_vld_o), 64'd0);
    ln = '0; ln[8*16 +: 8] = 8'h80;
    resp(3'd2, ln, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    chk("lat_vld", 64'(ruby_ld_resp_vld_o), 64'd1);
    drain();

    // Tag1 at offset 0x3C: LWU, LW, LD (LD must not wrap to bytes 0..3)
    ln = '0; ln[8*60 +: 32] = 32'h89AB_CDEF; ln[31:0] = 32'h1122_3344;
    req(3'd1, 6'h3C, 3'b110);
    resp(3'd1, ln, 1'b1, 64'h0000_0000_89AB_CDEF, 1'b0);
    req(3'd1, 6'h3C, 3'b010);
    resp(3'd1, ln, 1'b1, 64'hFFFF_FFFF_89AB_CDEF, 1'b0);
    req(3'd1, 6'h3C, 3'b011);
    resp(3'd1, ln, 1'b1, 64'h0000_0000_89AB_CDEF, 1'b0);
    drain();

    // Same-cycle response and new request on tag5
    req(3'd5, 6'h08, 3'b010);
    ln = '0; ln[8*8 +: 32] = 32'h1234_5678;
    ruby_ld_req_vld_i = 1'b1; ruby_ld_req_tag_i = 3'd5;
    ruby_ld_req_offset_i = 6'h00; ruby_ld_req_opcode_i = 3'b011;
    l1d_ld_resp_vld_i = 1'b1; l1d_ld_resp_tag_i = 3'd5; l1d_ld_resp_line_i = ln;
    @(negedge clk);
    chk("same_req_rdy",  64'(ruby_ld_req_rdy_o), 64'd0);
    chk("same_resp_rdy", 64'(l1d_ld_resp_rdy_o), 64'd1);
    @(posedge clk);
    #1 l1d_ld_resp_vld_i = 1'b0;
    e5.tag = 3'd5; e5.data = 64'h0000_0000_1234_5678; e5.mis = 1'b0;
    sb.push_back(e5);
    @(negedge clk);
    chk("same_req_rdy_next", 64'(ruby_ld_req_rdy_o), 64'd1);
    @(posedge clk);
    #1 ruby_ld_req_vld_i = 1'b0;
    ln = '0; ln[63:0] = 64'h0102_0304_0506_0708;
    resp(3'd5, ln, 1'b1, 64'h0102_0304_0506_0708, 1'b0);
    drain();

    // FIFO full back-pressure, then in-order drain and stalled 5th response
    ruby_ld_resp_rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) req(3'(i), 6'(i), (i < 4) ? 3'b100 : 3'b000);
    for (int i = 0; i < 4; i++) begin
      ln = '0; ln[8*i +: 8] = 8'(8'hA0 + i);
      resp(3'(i), ln, 1'b1, 64'(8'hA0 + i), 1'b0);
    end
    @(negedge clk);
    chk("full_resp_rdy", 64'(l1d_ld_resp_rdy_o), 64'd0);
    ln = '0; ln[8*4 +: 8] = 8'hFE;
    fork
      resp(3'd4, ln, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("stall_resp_rdy", 64'(l1d_ld_resp_rdy_o), 64'd0);
        chk("stall_head_tag", 64'(ruby_ld_resp_tag_o), 64'd0);
        chk("stall_pending",  64'(sb.size()),          64'd4);
        @(posedge clk);
        #1 ruby_ld_resp_rdy_i = 1'b1;
      end
    join
    drain();

    // LH at odd and even offsets
    ln = '0; ln[8*3 +: 8] = 8'h34; ln[8*4 +: 8] = 8'h92;
    req(3'd3, 6'h03, 3'b001);
`ifdef RUBY_LD_MISALIGN_CHK_EN
    resp(3'd3, ln, 1'b1, 64'd0, 1'b1);
`else
    resp(3'd3, ln, 1'b1, 64'hFFFF_FFFF_FFFF_9234, 1'b0);
`endif
    ln = '0; ln[8*2 +: 8] = 8'h78; ln[8*3 +: 8] = 8'h56;
    req(3'd3, 6'h02, 3'b001);
    resp(3'd3, ln, 1'b1, 64'h0000_0000_0000_5678, 1'b0);
    drain();

    // Unexpected response on tag6
    chk("err_before", 64'(unexp_resp_err_o), 64'd0);
    resp(3'd6, ln, 1'b0, 64'd0, 1'b0);
    chk("err_set", 64'(unexp_resp_err_o), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", 64'(unexp_resp_err_o),   64'd1);
    chk("unexp_vld",  64'(ruby_ld_resp_vld_o), 64'd0);

    // Reset with two results queued discards everything
    ruby_ld_resp_rdy_i = 1'b0;
    req(3'd0, 6'h00, 3'b100);
    req(3'd1, 6'h01, 3'b100);
    ln = '0; ln[7:0] = 8'h11; ln[15:8] = 8'h22;
    resp(3'd0, ln, 1'b0, 64'd0, 1'b0);
    resp(3'd1, ln, 1'b0, 64'd0, 1'b0);
    chk("queued_vld", 64'(ruby_ld_resp_vld_o), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst2_vld",      64'(ruby_ld_resp_vld_o),  64'd0);
    chk("rst2_data",     ruby_ld_resp_data_o,      64'd0);
    chk("rst2_err",      64'(unexp_resp_err_o),    64'd0);
    chk("rst2_resp_rdy", 64'(l1d_ld_resp_rdy_o),   64'd1);
    for (int t = 0; t < 8; t++) begin
      ruby_ld_req_tag_i = 3'(t);
      #1 chk("rst2_req_rdy", 64'(ruby_ld_req_rdy_o), 64'd1);
    end
    drain();
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
